osc_clkdiv: RTL



---
 rtl/osc_clkdiv.sv | 126 ++++++++++++
 1 files changed

// File: rtl/osc_clkdiv.sv
// rtl/osc_clkdiv.sv - multi-channel programmable tick generator with startup settle hold-off
// Optional square-wave debug outputs clk_o when OSC_CLKDIV_TOGGLE_EN is defined.
module osc_clkdiv #(
    parameter int CHANNELS       = 4,
    parameter int DIV_W          = 16,
    parameter int STARTUP_CYCLES = 1024,
    parameter int DEFAULT_DIV    = 50,
    localparam int SEL_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [SEL_W-1:0]    cfg_sel,
    input  logic [DIV_W-1:0]    cfg_div,
    input  logic                cfg_en,
`ifdef OSC_CLKDIV_TOGGLE_EN
    output logic [CHANNELS-1:0] clk_o,
`endif
    output logic [CHANNELS-1:0] tick_o,
    output logic                ready_o
);

    localparam int SU_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES + 1) : 1;
    localparam logic [SU_W-1:0] SU_LAST = SU_W'(STARTUP_CYCLES - 1);

    typedef enum logic {ST_SETTLE, ST_RUN} state_t;

    state_t          state_q, state_d;
    logic [SU_W-1:0] su_q, su_d;
    logic            sel_ok;

    // Divisors 0 and 1 both collapse to a zero reload, i.e. a tick every cycle.
    function automatic logic [DIV_W-1:0] reload_val(input logic [DIV_W-1:0] d);
        return (d == '0) ? '0 : d - DIV_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_SETTLE;
            su_q    <= '0;
        end else begin
            state_q <= state_d;
            su_q    <= su_d;
        end
    end

    always_comb begin
        state_d = state_q;
        su_d    = su_q;
        if (state_q == ST_SETTLE) begin
            su_d = su_q + SU_W'(1);
            if (su_q == SU_LAST) begin
                state_d = ST_RUN;
            end
        end
    end

    assign ready_o = (state_q == ST_RUN);

    generate
        if ((1 << SEL_W) > CHANNELS) begin : g_range
            localparam logic [SEL_W:0] CH_L = (SEL_W + 1)'(CHANNELS);
            assign sel_ok = ({1'b0, cfg_sel} < CH_L);
        end else begin : g_full
            assign sel_ok = 1'b1;
        end
    endgenerate

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_ch
            logic             hit;
            logic             en_r;
            logic             tick_r;
            logic [DIV_W-1:0] pend_r;
            logic [DIV_W-1:0] cnt_r;

            assign hit = cfg_we && sel_ok && (cfg_sel == SEL_W'(i));

            always_ff @(posedge clk) begin
                if (rst) begin
                    en_r   <= 1'b0;
                    tick_r <= 1'b0;
                    pend_r <= DIV_W'(DEFAULT_DIV);
                    cnt_r  <= reload_val(DIV_W'(DEFAULT_DIV));
                end else begin
                    tick_r <= 1'b0;
                    if (hit) begin
                        pend_r <= cfg_div;
                    end
                    if (hit && !cfg_en) begin
                        en_r <= 1'b0;
                    end else if (hit && !en_r) begin
                        en_r  <= 1'b1;
                        cnt_r <= reload_val(cfg_div);
                    end else if (en_r && ready_o) begin
                        // A write landing on the terminal count takes effect in this very reload.
                        if (cnt_r == '0) begin
                            tick_r <= 1'b1;
                            cnt_r  <= reload_val(hit ? cfg_div : pend_r);
                        end else begin
                            cnt_r <= cnt_r - DIV_W'(1);
                        end
                    end
                end
            end

            assign tick_o[i] = tick_r;

`ifdef OSC_CLKDIV_TOGGLE_EN
            logic tog_r;

            always_ff @(posedge clk) begin
                if (rst) begin
                    tog_r <= 1'b0;
                end else if (en_r && ready_o && !(hit && !cfg_en) && cnt_r == '0) begin
                    tog_r <= ~tog_r;
                end
            end

            assign clk_o[i] = tog_r;
`endif
        end
    endgenerate

endmodule
